// File: rtl/id_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module  : id_ex_operand_stage
// Brief   : ID/EX pipeline register with EX-stage RAW forwarding and ALU
//           operand select (porta/portb/aluop, store data, writeback info).
// Revision: 1.0
// ============================================================================
module id_ex_operand_stage #(
  parameter int DW  = 32,
  parameter int RW  = 5,
  parameter int OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_stall,
  input  logic           i_flush,
  input  logic           i_valid,
  input  logic [OPW-1:0] i_aluop,
  input  logic [RW-1:0]  i_rs,
  input  logic [RW-1:0]  i_rt,
  input  logic [DW-1:0]  i_rdata1,
  input  logic [DW-1:0]  i_rdata2,
  input  logic [DW-1:0]  i_imm,
  input  logic [4:0]     i_shamt,
  input  logic           i_shift,
  input  logic           i_alusrc,
  input  logic [RW-1:0]  i_wsel,
  input  logic           i_regwen,
  input  logic           i_exmem_regwen,
  input  logic [RW-1:0]  i_exmem_wsel,
  input  logic [DW-1:0]  i_exmem_wdat,
  input  logic           i_memwb_regwen,
  input  logic [RW-1:0]  i_memwb_wsel,
  input  logic [DW-1:0]  i_memwb_wdat,
  output logic [DW-1:0]  o_porta,
  output logic [DW-1:0]  o_portb,
  output logic [OPW-1:0] o_aluop,
  output logic           o_ex_valid,
  output logic [RW-1:0]  o_ex_wsel,
  output logic           o_ex_regwen,
  output logic [DW-1:0]  o_ex_storedat
);

  localparam int c_SHW = 5;

  logic           r_valid;
  logic [OPW-1:0] r_aluop;
  logic [RW-1:0]  r_rs;
  logic [RW-1:0]  r_rt;
  logic [DW-1:0]  r_rdata1;
  logic [DW-1:0]  r_rdata2;
  logic [DW-1:0]  r_imm;
  logic [4:0]     r_shamt;
  logic           r_shift;
  logic           r_alusrc;
  logic [RW-1:0]  r_wsel;
  logic           r_regwen;

  logic [DW-1:0]  w_fwd_rs;
  logic [DW-1:0]  w_fwd_rt;

  // A bubble clears every field so its operand outputs stay deterministic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_aluop  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_shamt  <= '0;
      r_shift  <= 1'b0;
      r_alusrc <= 1'b0;
      r_wsel   <= '0;
      r_regwen <= 1'b0;
    end else if (i_flush) begin
      r_valid  <= 1'b0;
      r_aluop  <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_shamt  <= '0;
      r_shift  <= 1'b0;
      r_alusrc <= 1'b0;
      r_wsel   <= '0;
      r_regwen <= 1'b0;
    end else if (!i_stall) begin
      r_valid  <= i_valid;
      r_aluop  <= i_aluop;
      r_rs     <= i_rs;
      r_rt     <= i_rt;
      r_rdata1 <= i_rdata1;
      r_rdata2 <= i_rdata2;
      r_imm    <= i_imm;
      r_shamt  <= i_shamt;
      r_shift  <= i_shift;
      r_alusrc <= i_alusrc;
      r_wsel   <= i_wsel;
      r_regwen <= i_regwen;
    end
  end

  // Younger producer (EX/MEM) wins; register 0 always reads its latched value.
  always_comb begin
    w_fwd_rs = r_rdata1;
    if (i_exmem_regwen && (i_exmem_wsel == r_rs) && (r_rs != '0))
      w_fwd_rs = i_exmem_wdat;
    else if (i_memwb_regwen && (i_memwb_wsel == r_rs) && (r_rs != '0))
      w_fwd_rs = i_memwb_wdat;
  end

  always_comb begin
    w_fwd_rt = r_rdata2;
    if (i_exmem_regwen && (i_exmem_wsel == r_rt) && (r_rt != '0))
      w_fwd_rt = i_exmem_wdat;
    else if (i_memwb_regwen && (i_memwb_wsel == r_rt) && (r_rt != '0))
      w_fwd_rt = i_memwb_wdat;
  end

  always_comb begin
    if (r_shift) begin
      o_porta = w_fwd_rt;
      o_portb = {{(DW-c_SHW){1'b0}}, r_shamt};
    end else begin
      o_porta = w_fwd_rs;
      o_portb = r_alusrc ? r_imm : w_fwd_rt;
    end
  end

  assign o_aluop       = r_aluop;
  assign o_ex_valid    = r_valid;
  assign o_ex_wsel     = r_wsel;
  assign o_ex_regwen   = r_regwen & r_valid;
  assign o_ex_storedat = w_fwd_rt;

endmodule
`default_nettype wire
